// File: rtl/lifo_arbiter_pkg.sv
// Shared types and defaults for the round-robin LIFO arbiter.
// Optional reject mode is selected with LIFO_ARB_REJECT_EN.
package lifo_arb_pkg;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_DEF   = 16;

  // Wide enough for up to 16 requesters.
  localparam int ID_W = 4;

  typedef struct packed {
    logic            vld;
    logic            is_pop;
    logic            err;
    logic [ID_W-1:0] id;
  } stage_t;

  function automatic int cnt_w(int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lifo_arbiter_if.sv
// Requester-side request/grant/response bundle of the LIFO arbiter.
// rsp_err exists only when LIFO_ARB_REJECT_EN is defined.
interface lifo_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);

  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_op;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        gnt;
  logic                      rsp_valid;
  logic [IW-1:0]             rsp_id;
  logic [DATA_W-1:0]         rsp_data;
`ifdef LIFO_ARB_REJECT_EN
  logic                      rsp_err;
`endif

  modport master (
    output req_valid,
    output req_op,
    output req_data,
`ifdef LIFO_ARB_REJECT_EN
    input  rsp_err,
`endif
    input  gnt,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_data,
`ifdef LIFO_ARB_REJECT_EN
    output rsp_err,
`endif
    output gnt,
    output rsp_valid,
    output rsp_id,
    output rsp_data
  );

endinterface

// File: rtl/lifo_arbiter_rr_arbiter.sv
// Masked round-robin picker: lowest eligible index at or above ptr,
// otherwise lowest eligible index overall.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] hi;
  logic [NUM_REQ-1:0] pick;

  always_comb begin
    mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mask[i] = (i >= int'(ptr));
    end
  end

  assign hi   = elig & mask;
  assign pick = (|hi) ? hi : elig;
  // Isolate the lowest set bit.
  assign gnt  = pick & (~pick + NUM_REQ'(1));
  assign any  = |elig;

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/lifo_arbiter.sv
// Round-robin sharing of one LIFO stack between NUM_REQ requesters.
// LIFO_ARB_REJECT_EN: grant illegal ops and answer them with rsp_err.
module lifo_arbiter
  import lifo_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int DEPTH   = DEPTH_DEF,
  localparam int IW      = $clog2(NUM_REQ),
  localparam int CW      = cnt_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  lifo_arbiter_if.slave     bus,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_din,
  input  logic [DATA_W-1:0] stk_dout,
  output logic [CW-1:0]     count
);

  logic [NUM_REQ-1:0] legal;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] bad;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [IW-1:0]      g_idx;
  logic               g_any;
  logic               g_pop;
  logic               g_err;
  logic [DATA_W-1:0]  g_data;
  logic               not_full;
  logic               not_empty;

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      ptr_nxt;
  logic [CW-1:0]      count_nxt;
  stage_t             s1;
  stage_t             s1_nxt;
  stage_t             s2;
  stage_t             s2_nxt;
  logic               push_nxt;
  logic               pop_nxt;
  logic [DATA_W-1:0]  din_nxt;

  assign not_full  = (count < CW'(DEPTH));
  assign not_empty = (count != '0);

  always_comb begin
    legal = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      legal[i] = (bus.req_op[i] == OP_PUSH)
               ? not_full : not_empty;
    end
  end

`ifdef LIFO_ARB_REJECT_EN
  assign elig = bus.req_valid & {NUM_REQ{~rst}};
  assign bad  = bus.req_valid & ~legal;
`else
  assign elig = bus.req_valid & legal
              & {NUM_REQ{~rst}};
  assign bad  = '0;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .elig (elig),
    .ptr  (ptr),
    .gnt  (gnt_vec),
    .idx  (g_idx),
    .any  (g_any)
  );

  assign bus.gnt = gnt_vec;
  assign g_pop   = (bus.req_op[g_idx] == OP_POP);
  assign g_err   = bad[g_idx];
  assign g_data  = bus.req_data[g_idx*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      stk_din  <= '0;
      count    <= '0;
      ptr      <= '0;
    end else begin
      s1       <= s1_nxt;
      s2       <= s2_nxt;
      stk_push <= push_nxt;
      stk_pop  <= pop_nxt;
      stk_din  <= din_nxt;
      count    <= count_nxt;
      ptr      <= ptr_nxt;
    end
  end

  // Stage chain: grant (IDLE) -> ISSUE in s1 -> RESP in s2.
  always_comb begin
    s1_nxt    = '0;
    s2_nxt    = s1;
    push_nxt  = 1'b0;
    pop_nxt   = 1'b0;
    din_nxt   = stk_din;
    count_nxt = count;
    ptr_nxt   = ptr;
    if (g_any) begin
      s1_nxt.vld    = 1'b1;
      s1_nxt.is_pop = g_pop;
      s1_nxt.err    = g_err;
      s1_nxt.id     = ID_W'(g_idx);
      push_nxt      = ~g_pop & ~g_err;
      pop_nxt       = g_pop & ~g_err;
      if (g_idx == IW'(NUM_REQ - 1)) begin
        ptr_nxt = '0;
      end else begin
        ptr_nxt = g_idx + IW'(1);
      end
    end
    if (push_nxt) begin
      din_nxt   = g_data;
      count_nxt = count + CW'(1);
    end else if (pop_nxt) begin
      count_nxt = count - CW'(1);
    end
  end

  always_comb begin
    bus.rsp_valid = s2.vld & (s2.is_pop | s2.err);
    bus.rsp_id    = IW'(s2.id);
    bus.rsp_data  = '0;
    // Stack read data is valid exactly in the RESP cycle.
    if (bus.rsp_valid && !s2.err) begin
      bus.rsp_data = stk_dout;
    end
`ifdef LIFO_ARB_REJECT_EN
    bus.rsp_err   = bus.rsp_valid & s2.err;
`endif
  end

endmodule

// File: tb/tb_lifo_arbiter.sv
// Directed bench for lifo_arbiter with a reference stack and response queue.
// Honours LIFO_ARB_REJECT_EN when defined.
module tb_lifo_arbiter;
  import lifo_arb_pkg::*;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
`ifdef LIFO_ARB_REJECT_EN
  localparam bit REJ = 1'b1;
`else
  localparam bit REJ = 1'b0;
`endif

  typedef struct {
    int         due;
    int         id;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_din;
  logic [7:0] stk_dout;
  logic [4:0] count;

  always #5 clk = ~clk;

  lifo_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  lifo_arbiter #(
    .NUM_REQ (NR),
    .DATA_W  (DW),
    .DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .stk_push (stk_push),
    .stk_pop  (stk_pop),
    .stk_din  (stk_din),
    .stk_dout (stk_dout),
    .count    (count)
  );

  // Behavioural stack: read data appears the cycle after stk_pop.
  logic [7:0] mem [16];
  logic [4:0] sp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp       <= '0;
      stk_dout <= '0;
    end else begin
      if (stk_push && sp < 5'd16) begin
        mem[sp[3:0]] <= stk_din;
        sp           <= sp + 5'd1;
      end
      if (stk_pop && sp > 5'd0) begin
        stk_dout <= mem[sp[3:0] - 4'd1];
        sp       <= sp - 5'd1;
      end
    end
  end

  int         checks;
  int         failures;
  int         cyc_n;
  int         mptr;
  int         last_g;
  int         dseq;
  logic       pend_push;
  logic       pend_pop;
  logic [7:0] pend_din;
  logic [3:0] obs_gnt;
  logic [7:0] mstk [$];
  exp_t       sb [$];

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(int i, logic v, logic op, logic [7:0] d);
    bus.req_valid[i]        = v;
    bus.req_op[i]           = op;
    bus.req_data[i*8 +: 8]  = d;
  endtask

  task automatic bump();
    if (last_g >= 0) begin
      bus.req_data[last_g*8 +: 8] = 8'(dseq);
      dseq++;
    end
  endtask

  task automatic cyc();
    int         g;
    int         j;
    logic       ok;
    logic       lg;
    logic       erv;
    logic [7:0] d;
    logic [3:0] eg;
    exp_t       e;
    @(negedge clk);
    cyc_n++;
    obs_gnt = bus.gnt;
    last_g  = -1;
    if (rst) begin
      mstk.delete();
      sb.delete();
      mptr      = 0;
      pend_push = 1'b0;
      pend_pop  = 1'b0;
      chk("rst_gnt", bus.gnt, 0);
      chk("rst_push", stk_push, 0);
      chk("rst_pop", stk_pop, 0);
      chk("rst_din", stk_din, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_id", bus.rsp_id, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_count", count, 0);
`ifdef LIFO_ARB_REJECT_EN
      chk("rst_rsp_err", bus.rsp_err, 0);
`endif
    end else begin
      chk("stk_push", stk_push, pend_push);
      chk("stk_pop", stk_pop, pend_pop);
      if (pend_push) chk("stk_din", stk_din, pend_din);
      chk("count", count, mstk.size());
      erv = (sb.size() > 0) && (sb[0].due == cyc_n);
      chk("rsp_valid", bus.rsp_valid, erv);
      if (erv) begin
        e = sb.pop_front();
        chk("rsp_id", bus.rsp_id, e.id);
        chk("rsp_data", bus.rsp_data, e.data);
`ifdef LIFO_ARB_REJECT_EN
        chk("rsp_err", bus.rsp_err, e.err);
`endif
      end
      g = -1;
      for (int k = 0; k < NR; k++) begin
        j  = (mptr + k) % NR;
        lg = bus.req_op[j] ? (mstk.size() > 0)
                           : (mstk.size() < DEPTH);
        ok = bus.req_valid[j] && (lg || REJ);
        if (g < 0 && ok) g = j;
      end
      eg = (g < 0) ? 4'b0000 : 4'(1 << g);
      chk("gnt", bus.gnt, eg);
      pend_push = 1'b0;
      pend_pop  = 1'b0;
      last_g    = g;
      if (g >= 0) begin
        mptr = (g + 1) % NR;
        lg = bus.req_op[g] ? (mstk.size() > 0)
                           : (mstk.size() < DEPTH);
        if (!lg) begin
          sb.push_back('{cyc_n + 2, g, 8'h00, 1'b1});
        end else if (bus.req_op[g]) begin
          d        = mstk.pop_back();
          pend_pop = 1'b1;
          sb.push_back('{cyc_n + 2, g, d, 1'b0});
        end else begin
          d         = bus.req_data[g*8 +: 8];
          mstk.push_back(d);
          pend_push = 1'b1;
          pend_din  = d;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    cyc_n         = 0;
    mptr          = 0;
    last_g        = -1;
    dseq          = 8'h40;
    pend_push     = 1'b0;
    pend_pop      = 1'b0;
    pend_din      = '0;
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_data  = '0;
    #1 rst = 1'b1;

    // Reset with every requester asking.
    for (int i = 0; i < NR; i++) drive(i, 1'b1, OP_PUSH, 8'(8'h10 + i));
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    chk("first_gnt", obs_gnt, 4'b0001);
    bump();

    // Continuous pushes until full, then stall.
    repeat (20) begin
      cyc();
      bump();
    end
    chk("full_count", count, 16);

    // Drain with pops from everyone.
    for (int i = 0; i < NR; i++) bus.req_op[i] = OP_POP;
    repeat (20) cyc();
    bus.req_valid = '0;
    repeat (3) cyc();
    chk("empty_count", count, 0);

    // Push 0xA5 then immediate pop by another requester.
    drive(1, 1'b1, OP_PUSH, 8'hA5);
    cyc();
    drive(1, 1'b0, OP_PUSH, 8'h00);
    drive(2, 1'b1, OP_POP, 8'h00);
    cyc();
    drive(2, 1'b0, OP_POP, 8'h00);
    repeat (3) cyc();

    // Empty stack: pop stalls, push skips ahead.
    drive(0, 1'b1, OP_POP, 8'h00);
    drive(3, 1'b1, OP_PUSH, 8'h3C);
    cyc();
    chk("skip_gnt", obs_gnt, 4'b1000);
    drive(3, 1'b0, OP_PUSH, 8'h00);
    cyc();
    chk("pop_gnt", obs_gnt, 4'b0001);
    drive(0, 1'b0, OP_POP, 8'h00);
    repeat (3) cyc();

    // Reset while a pop is in ISSUE.
    drive(2, 1'b1, OP_PUSH, 8'h77);
    cyc();
    drive(2, 1'b0, OP_PUSH, 8'h00);
    drive(1, 1'b1, OP_POP, 8'h00);
    cyc();
    drive(1, 1'b0, OP_POP, 8'h00);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (4) cyc();
    chk("post_rst_count", count, 0);

`ifdef LIFO_ARB_REJECT_EN
    // Illegal pop is granted and answered with an error.
    drive(0, 1'b1, OP_POP, 8'h00);
    cyc();
    chk("rej_gnt", obs_gnt, 4'b0001);
    drive(0, 1'b0, OP_POP, 8'h00);
    repeat (3) cyc();
`endif

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
